scen_cfg_sequencer: RTL and testbench

- Transmit-side counterpart of controller_integrated's configuration interface.
- Holds a small scenario table of (delay, object-id) entries and replays it onto the boot-up / table-parse / global-scenario-NoC handshake that controller_integrated receives.
- Generates the full boot sequence and later scenario-update bursts, replacing hand-timed stimulus with a synthesizable on-chip sequencer.

---
 rtl/scen_cfg_sequencer.sv | 276 +++++++++++++++++++++++++++
 tb/tb_scen_cfg_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scen_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : scen_cfg_sequencer
// Brief    : Replays a small (delay, object-id) scenario table onto the
//            boot-up / table-parse / global-scenario handshake of a controller.
// Revision : 1.0
// ============================================================================
module scen_cfg_sequencer #(
    parameter int N_OBJ        = 4,
    parameter int DELAY_LENGTH = 14,
    parameter int OBJ_ID_WIDTH = 2,
    parameter int BOOT_TAIL    = 4,
    parameter int PARSE_WAIT   = 7,
    parameter int LOCAL_CYCLES = 32,
    parameter int EMIT_GAP     = 5,
    parameter int TBL_GAP      = 4,
    parameter int ADDR_W       = (N_OBJ > 1) ? $clog2(N_OBJ) : 1,
    parameter int NUM_W        = $clog2(N_OBJ + 1)
) (
    input  logic                    CLK,
    input  logic                    reset,
    input  logic                    cfg_we,
    input  logic [ADDR_W-1:0]       cfg_addr,
    input  logic [DELAY_LENGTH-1:0] cfg_delay,
    input  logic [OBJ_ID_WIDTH-1:0] cfg_obj_id,
    input  logic [NUM_W-1:0]        num_entries,
    input  logic                    cmd_boot,
    input  logic                    cmd_update,
    output logic                    boot_up,
    output logic                    table_parse,
    output logic                    boot_up_local,
    output logic                    boot_up_table_update,
    output logic                    input_valid,
    output logic                    glob_scen_noc_input_valid,
    output logic [DELAY_LENGTH-1:0] delay_matrix_element,
    output logic [OBJ_ID_WIDTH-1:0] obj_id_element,
    output logic                    start,
    output logic                    busy,
    output logic                    done
);

    localparam int c_CNT_MAX = BOOT_TAIL + PARSE_WAIT + LOCAL_CYCLES + EMIT_GAP
                             + TBL_GAP + 2 * N_OBJ;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_B_EMIT  = 4'd1,
        S_B_TAIL  = 4'd2,
        S_P_WAIT  = 4'd3,
        S_LOCAL   = 4'd4,
        S_G_GAP   = 4'd5,
        S_G_EMIT  = 4'd6,
        S_T_GAP   = 4'd7,
        S_T_PULSE = 4'd8,
        S_U_START = 4'd9
    } state_t;

    // Scenario table
    logic [DELAY_LENGTH-1:0] r_tbl_delay [N_OBJ];
    logic [OBJ_ID_WIDTH-1:0] r_tbl_obj   [N_OBJ];

    // Sequencer state
    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [NUM_W-1:0]   r_n;
    logic [NUM_W-1:0]   w_n_nxt;
    logic               r_is_boot;
    logic               w_is_boot_nxt;

    // Registered outputs and their next values
    logic                    r_boot_up,      w_boot_up_nxt;
    logic                    r_table_parse,  w_table_parse_nxt;
    logic                    r_local,        w_local_nxt;
    logic                    r_tbl_upd,      w_tbl_upd_nxt;
    logic                    r_in_vld,       w_in_vld_nxt;
    logic                    r_glob_vld,     w_glob_vld_nxt;
    logic [DELAY_LENGTH-1:0] r_delay,        w_delay_nxt;
    logic [OBJ_ID_WIDTH-1:0] r_obj,          w_obj_nxt;
    logic                    r_start,        w_start_nxt;
    logic                    r_busy,         w_busy_nxt;
    logic                    r_done,         w_done_nxt;

    logic [NUM_W-1:0]   w_n_clamp;
    logic [c_CNT_W-1:0] w_emit_last;
    logic [ADDR_W-1:0]  w_idx;
    logic               w_wr_ok;

    assign w_n_clamp   = (num_entries > NUM_W'(N_OBJ)) ? NUM_W'(N_OBJ) : num_entries;
    // Each entry occupies a valid cycle and a gap cycle: entry k sits at count 2k
    assign w_emit_last = c_CNT_W'({r_n, 1'b0}) - c_CNT_W'(1);
    assign w_idx       = r_cnt[ADDR_W:1];
    assign w_wr_ok     = cfg_we && !r_busy && (int'(cfg_addr) < N_OBJ);

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_OBJ; i++) begin
                r_tbl_delay[i] <= '0;
                r_tbl_obj[i]   <= '0;
            end
        end else if (w_wr_ok) begin
            r_tbl_delay[cfg_addr] <= cfg_delay;
            r_tbl_obj[cfg_addr]   <= cfg_obj_id;
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_n           <= '0;
            r_is_boot     <= 1'b0;
            r_boot_up     <= 1'b0;
            r_table_parse <= 1'b0;
            r_local       <= 1'b0;
            r_tbl_upd     <= 1'b0;
            r_in_vld      <= 1'b0;
            r_glob_vld    <= 1'b0;
            r_delay       <= '0;
            r_obj         <= '0;
            r_start       <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_n           <= w_n_nxt;
            r_is_boot     <= w_is_boot_nxt;
            r_boot_up     <= w_boot_up_nxt;
            r_table_parse <= w_table_parse_nxt;
            r_local       <= w_local_nxt;
            r_tbl_upd     <= w_tbl_upd_nxt;
            r_in_vld      <= w_in_vld_nxt;
            r_glob_vld    <= w_glob_vld_nxt;
            r_delay       <= w_delay_nxt;
            r_obj         <= w_obj_nxt;
            r_start       <= w_start_nxt;
            r_busy        <= w_busy_nxt;
            r_done        <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt + c_CNT_W'(1);
        w_n_nxt           = r_n;
        w_is_boot_nxt     = r_is_boot;
        w_boot_up_nxt     = r_boot_up;
        w_table_parse_nxt = r_table_parse;
        w_local_nxt       = r_local;
        w_tbl_upd_nxt     = 1'b0;
        w_in_vld_nxt      = 1'b0;
        w_glob_vld_nxt    = 1'b0;
        w_delay_nxt       = r_delay;
        w_obj_nxt         = r_obj;
        w_start_nxt       = 1'b0;
        w_busy_nxt        = r_busy;
        w_done_nxt        = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (cmd_boot) begin
                    w_n_nxt       = w_n_clamp;
                    w_is_boot_nxt = 1'b1;
                    w_boot_up_nxt = 1'b1;
                    w_busy_nxt    = 1'b1;
                    w_state_nxt   = (w_n_clamp != '0) ? S_B_EMIT : S_B_TAIL;
                end else if (cmd_update) begin
                    w_n_nxt       = w_n_clamp;
                    w_is_boot_nxt = 1'b0;
                    w_start_nxt   = 1'b1;
                    w_busy_nxt    = 1'b1;
                    w_state_nxt   = S_U_START;
                end
            end

            S_B_EMIT: begin
                if (!r_cnt[0]) begin
                    w_in_vld_nxt = 1'b1;
                    w_delay_nxt  = r_tbl_delay[w_idx];
                    w_obj_nxt    = r_tbl_obj[w_idx];
                end
                if (r_cnt == w_emit_last) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_B_TAIL;
                end
            end

            S_B_TAIL: begin
                if (r_cnt == c_CNT_W'(BOOT_TAIL)) begin
                    w_boot_up_nxt = 1'b0;
                    w_cnt_nxt     = '0;
                    w_state_nxt   = S_P_WAIT;
                end
            end

            S_P_WAIT: begin
                if (r_cnt == c_CNT_W'(PARSE_WAIT - 1)) begin
                    w_table_parse_nxt = 1'b1;
                    w_local_nxt       = 1'b1;
                    w_cnt_nxt         = '0;
                    w_state_nxt       = S_LOCAL;
                end
            end

            S_LOCAL: begin
                if (r_cnt == c_CNT_W'(LOCAL_CYCLES - 1)) begin
                    w_local_nxt = 1'b0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_G_GAP;
                end
            end

            // The first global entry lands EMIT_GAP edges after the triggering edge
            S_G_GAP, S_U_START: begin
                if (r_cnt == c_CNT_W'(EMIT_GAP - 2)) begin
                    w_cnt_nxt = '0;
                    if (r_n != '0)
                        w_state_nxt = S_G_EMIT;
                    else
                        w_state_nxt = r_is_boot ? S_T_GAP : S_T_PULSE;
                end
            end

            S_G_EMIT: begin
                if (!r_cnt[0]) begin
                    w_glob_vld_nxt = 1'b1;
                    w_delay_nxt    = r_tbl_delay[w_idx];
                    w_obj_nxt      = r_tbl_obj[w_idx];
                end
                if (r_cnt == w_emit_last) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = r_is_boot ? S_T_GAP : S_T_PULSE;
                end
            end

            S_T_GAP: begin
                if (r_cnt == c_CNT_W'(TBL_GAP)) begin
                    w_tbl_upd_nxt = 1'b1;
                    w_cnt_nxt     = '0;
                    w_state_nxt   = S_T_PULSE;
                end
            end

            // Final step of both sequences; the table-update pulse (boot only) is high here
            S_T_PULSE: begin
                w_done_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign boot_up                   = r_boot_up;
    assign table_parse               = r_table_parse;
    assign boot_up_local             = r_local;
    assign boot_up_table_update      = r_tbl_upd;
    assign input_valid               = r_in_vld;
    assign glob_scen_noc_input_valid = r_glob_vld;
    assign delay_matrix_element      = r_delay;
    assign obj_id_element            = r_obj;
    assign start                     = r_start;
    assign busy                      = r_busy;
    assign done                      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_scen_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_scen_cfg_sequencer
// Brief    : Directed bench for scen_cfg_sequencer with an event scoreboard.
// Revision : 1.0
// ============================================================================
module tb_scen_cfg_sequencer;

    localparam int c_BT = 4;
    localparam int c_PW = 7;
    localparam int c_LC = 32;
    localparam int c_EG = 5;
    localparam int c_TG = 4;

    localparam int EV_BU_RISE  = 0;
    localparam int EV_BU_FALL  = 1;
    localparam int EV_TP_RISE  = 2;
    localparam int EV_LOC_RISE = 3;
    localparam int EV_LOC_FALL = 4;
    localparam int EV_IN       = 5;
    localparam int EV_GLOB     = 6;
    localparam int EV_START    = 7;
    localparam int EV_TBL      = 8;
    localparam int EV_DONE     = 9;

    typedef struct {
        int cyc;
        int kind;
        int dly;
        int oid;
    } ev_t;

    logic        CLK = 1'b0;
    logic        reset;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [13:0] cfg_delay;
    logic [1:0]  cfg_obj_id;
    logic [2:0]  num_entries;
    logic        cmd_boot;
    logic        cmd_update;
    logic        boot_up;
    logic        table_parse;
    logic        boot_up_local;
    logic        boot_up_table_update;
    logic        input_valid;
    logic        glob_scen_noc_input_valid;
    logic [13:0] delay_matrix_element;
    logic [1:0]  obj_id_element;
    logic        start;
    logic        busy;
    logic        done;

    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   mon_en   = 1'b0;
    bit   tp_model = 1'b0;
    logic p_bu     = 1'b0;
    logic p_tp     = 1'b0;
    logic p_loc    = 1'b0;
    int   m_dly [4];
    int   m_oid [4];
    ev_t  exp_q [$];

    scen_cfg_sequencer dut (
        .CLK                       (CLK),
        .reset                     (reset),
        .cfg_we                    (cfg_we),
        .cfg_addr                  (cfg_addr),
        .cfg_delay                 (cfg_delay),
        .cfg_obj_id                (cfg_obj_id),
        .num_entries               (num_entries),
        .cmd_boot                  (cmd_boot),
        .cmd_update                (cmd_update),
        .boot_up                   (boot_up),
        .table_parse               (table_parse),
        .boot_up_local             (boot_up_local),
        .boot_up_table_update      (boot_up_table_update),
        .input_valid               (input_valid),
        .glob_scen_noc_input_valid (glob_scen_noc_input_valid),
        .delay_matrix_element      (delay_matrix_element),
        .obj_id_element            (obj_id_element),
        .start                     (start),
        .busy                      (busy),
        .done                      (done)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [24:0] out_vec();
        return {boot_up, table_parse, boot_up_local, boot_up_table_update, input_valid,
                glob_scen_noc_input_valid, delay_matrix_element, obj_id_element,
                start, busy, done};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Expected events kept ordered by (cycle, kind), matching the monitor's scan order
    function automatic void push_ev(input int c, input int k, input int d, input int o);
        ev_t e;
        int  i;
        e.cyc = c; e.kind = k; e.dly = d; e.oid = o;
        i = exp_q.size();
        while (i > 0 && (exp_q[i-1].cyc > c || (exp_q[i-1].cyc == c && exp_q[i-1].kind > k)))
            i--;
        exp_q.insert(i, e);
    endfunction

    task automatic observe(input int k);
        ev_t e;
        int  d;
        int  o;
        d = (k == EV_IN || k == EV_GLOB) ? int'(delay_matrix_element) : 0;
        o = (k == EV_IN || k == EV_GLOB) ? int'(obj_id_element) : 0;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL event: got kind=%0d cyc=%0d delay=%0d id=%0d, required no event", k, cyc, d, o);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.cyc != cyc || e.dly != d || e.oid != o) begin
                n_fail++;
                $display("FAIL event: got kind=%0d cyc=%0d delay=%0d id=%0d, required kind=%0d cyc=%0d delay=%0d id=%0d",
                         k, cyc, d, o, e.kind, e.cyc, e.dly, e.oid);
            end
        end
    endtask

    always @(negedge CLK) begin
        if (mon_en) begin
            if (input_valid || glob_scen_noc_input_valid) begin
                n_checks++;
                if (input_valid && glob_scen_noc_input_valid) begin
                    n_fail++;
                    $display("FAIL valid_exclusive: got both valids=1 at cyc %0d, required at most one", cyc);
                end
            end
            if (boot_up && !p_bu)        observe(EV_BU_RISE);
            if (!boot_up && p_bu)        observe(EV_BU_FALL);
            if (table_parse && !p_tp)    observe(EV_TP_RISE);
            if (boot_up_local && !p_loc) observe(EV_LOC_RISE);
            if (!boot_up_local && p_loc) observe(EV_LOC_FALL);
            if (input_valid)               observe(EV_IN);
            if (glob_scen_noc_input_valid) observe(EV_GLOB);
            if (start)                     observe(EV_START);
            if (boot_up_table_update)      observe(EV_TBL);
            if (done)                      observe(EV_DONE);
        end
        p_bu  <= boot_up;
        p_tp  <= table_parse;
        p_loc <= boot_up_local;
    end

    task automatic wr(input int a, input int d, input int o, input bit accepted);
        @(negedge CLK);
        cfg_we = 1'b1; cfg_addr = 2'(a); cfg_delay = 14'(d); cfg_obj_id = 2'(o);
        @(negedge CLK);
        cfg_we = 1'b0;
        if (accepted) begin
            m_dly[a] = d;
            m_oid[a] = o;
        end
    endtask

    task automatic begin_cmd(input bit b, input bit u, output int e0);
        @(negedge CLK);
        cmd_boot = b; cmd_update = u;
        e0 = cyc + 1;
    endtask

    task automatic end_cmd();
        @(negedge CLK);
        cmd_boot = 1'b0; cmd_update = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int i;
        i = 0;
        do begin
            @(negedge CLK);
            i++;
        end while (!done && i < budget);
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: done=0 after %0d cycles, required done=1", name, budget);
        end
    endtask

    // Boot timeline from its published offsets, for n already-clamped entries
    function automatic void exp_boot(input int e0, input int n);
        int bf, lr, lf, gs, pu;
        push_ev(e0, EV_BU_RISE, 0, 0);
        for (int k = 0; k < n; k++) push_ev(e0 + 1 + 2 * k, EV_IN, m_dly[k], m_oid[k]);
        bf = e0 + 1 + 2 * n + c_BT;
        lr = bf + c_PW;
        lf = lr + c_LC;
        gs = lf + c_EG;
        pu = gs + 2 * n + c_TG;
        push_ev(bf, EV_BU_FALL, 0, 0);
        if (!tp_model) push_ev(lr, EV_TP_RISE, 0, 0);
        tp_model = 1'b1;
        push_ev(lr, EV_LOC_RISE, 0, 0);
        push_ev(lf, EV_LOC_FALL, 0, 0);
        for (int k = 0; k < n; k++) push_ev(gs + 2 * k, EV_GLOB, m_dly[k], m_oid[k]);
        push_ev(pu, EV_TBL, 0, 0);
        push_ev(pu + 1, EV_DONE, 0, 0);
    endfunction

    initial begin
        int e0;
        int i;
        reset = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_delay = '0; cfg_obj_id = '0;
        num_entries = '0; cmd_boot = 1'b0; cmd_update = 1'b0;
        for (int k = 0; k < 4; k++) begin m_dly[k] = 0; m_oid[k] = 0; end

        repeat (2) @(negedge CLK);
        chk("reset_outputs", 32'(out_vec()), 32'd0);
        reset = 1'b0;
        @(negedge CLK);
        mon_en = 1'b1;

        // Full boot with two entries, absolute offsets from the reference timeline
        wr(0, 10000, 1, 1'b1);
        wr(1, 10010, 0, 1'b1);
        num_entries = 3'd2;
        begin_cmd(1'b1, 1'b0, e0);
        push_ev(e0,      EV_BU_RISE,  0,     0);
        push_ev(e0 + 1,  EV_IN,       10000, 1);
        push_ev(e0 + 3,  EV_IN,       10010, 0);
        push_ev(e0 + 9,  EV_BU_FALL,  0,     0);
        push_ev(e0 + 16, EV_TP_RISE,  0,     0);
        push_ev(e0 + 16, EV_LOC_RISE, 0,     0);
        push_ev(e0 + 48, EV_LOC_FALL, 0,     0);
        push_ev(e0 + 53, EV_GLOB,     10000, 1);
        push_ev(e0 + 55, EV_GLOB,     10010, 0);
        push_ev(e0 + 61, EV_TBL,      0,     0);
        push_ev(e0 + 62, EV_DONE,     0,     0);
        tp_model = 1'b1;
        end_cmd();
        repeat (3) @(negedge CLK);
        chk("busy_in_boot", 32'(busy), 32'd1);
        wr(1, 999, 3, 1'b0);
        begin_cmd(1'b0, 1'b1, i);
        end_cmd();
        wait_done(200, "boot_two_entries");
        chk("busy_after_boot", 32'(busy), 32'd0);
        chk("table_parse_sticky", 32'(table_parse), 32'd1);

        // Update burst after modifying entry 0
        wr(0, 10001, 1, 1'b1);
        begin_cmd(1'b0, 1'b1, e0);
        push_ev(e0,     EV_START, 0,     0);
        push_ev(e0 + 5, EV_GLOB,  10001, 1);
        push_ev(e0 + 7, EV_GLOB,  10010, 0);
        push_ev(e0 + 9, EV_DONE,  0,     0);
        end_cmd();
        wait_done(50, "update_two_entries");

        // Empty scenario still runs the whole boot handshake
        num_entries = 3'd0;
        begin_cmd(1'b1, 1'b0, e0);
        exp_boot(e0, 0);
        end_cmd();
        wait_done(200, "boot_zero_entries");

        // Oversized count with both commands raised: boot wins, four entries
        wr(2, 5, 2, 1'b1);
        wr(3, 16383, 3, 1'b1);
        num_entries = 3'd7;
        begin_cmd(1'b1, 1'b1, e0);
        exp_boot(e0, 4);
        end_cmd();
        wait_done(200, "boot_clamped");

        // Asynchronous reset while boot_up_local is high
        num_entries = 3'd4;
        begin_cmd(1'b1, 1'b0, e0);
        exp_boot(e0, 4);
        end_cmd();
        i = 0;
        while (!boot_up_local && i < 100) begin
            @(negedge CLK);
            i++;
        end
        chk("local_reached", 32'(boot_up_local), 32'd1);
        repeat (3) @(negedge CLK);
        mon_en = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("reset_mid_local", 32'(out_vec()), 32'd0);
        chk("reset_table_parse", 32'(table_parse), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        exp_q.delete();
        tp_model = 1'b0;
        for (int k = 0; k < 4; k++) begin m_dly[k] = 0; m_oid[k] = 0; end
        @(negedge CLK);
        reset = 1'b0;
        @(negedge CLK);
        mon_en = 1'b1;

        begin_cmd(1'b0, 1'b1, e0);
        push_ev(e0, EV_START, 0, 0);
        for (int k = 0; k < 4; k++) push_ev(e0 + c_EG + 2 * k, EV_GLOB, 0, 0);
        push_ev(e0 + c_EG + 8, EV_DONE, 0, 0);
        end_cmd();
        wait_done(50, "update_after_reset");

        repeat (6) @(negedge CLK);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_events: got %0d unobserved, required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
